// File: rtl/instruction_fetcher_if.sv
// Fetch-stage bus bundle: icache request/response, branch predictor query and feedback,
// ROB branch/flush notifications and instruction-queue push.
interface instruction_fetcher_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic                  IFIC_en;
    logic [ADDR_WIDTH-1:0] IFIC_pc;
    logic                  ICIF_en;
    logic [INST_WIDTH-1:0] ICIF_inst;

    logic                  IFPD_predict_en;
    logic [ADDR_WIDTH-1:0] IFPD_pc;
    logic                  PDIF_en;
    logic                  PDIF_predict_result;
    logic                  IFPD_feedback_en;
    logic                  IFPD_branch_result;
    logic [ADDR_WIDTH-1:0] IFPD_feedback_pc;

    logic                  ROBIF_branch_en;
    logic                  ROBIF_branch_result;
    logic [ADDR_WIDTH-1:0] ROBIF_branch_pc;
    logic                  ROBIF_flush_en;
    logic [ADDR_WIDTH-1:0] ROBIF_flush_pc;

    logic                  IQIF_full;
    logic                  IFIQ_en;
    logic [INST_WIDTH-1:0] IFIQ_inst;
    logic [ADDR_WIDTH-1:0] IFIQ_pc;
    logic                  IFIQ_pred_taken;

    // The fetcher drives the bus as master
    modport master (
        output IFIC_en, IFIC_pc,
        input  ICIF_en, ICIF_inst,
        output IFPD_predict_en, IFPD_pc,
        input  PDIF_en, PDIF_predict_result,
        output IFPD_feedback_en, IFPD_branch_result, IFPD_feedback_pc,
        input  ROBIF_branch_en, ROBIF_branch_result, ROBIF_branch_pc,
        input  ROBIF_flush_en, ROBIF_flush_pc,
        input  IQIF_full,
        output IFIQ_en, IFIQ_inst, IFIQ_pc, IFIQ_pred_taken
    );

    modport slave (
        input  IFIC_en, IFIC_pc,
        output ICIF_en, ICIF_inst,
        input  IFPD_predict_en, IFPD_pc,
        output PDIF_en, PDIF_predict_result,
        input  IFPD_feedback_en, IFPD_branch_result, IFPD_feedback_pc,
        output ROBIF_branch_en, ROBIF_branch_result, ROBIF_branch_pc,
        output ROBIF_flush_en, ROBIF_flush_pc,
        output IQIF_full,
        input  IFIQ_en, IFIQ_inst, IFIQ_pc, IFIQ_pred_taken
    );
endinterface

// File: rtl/instruction_fetcher.sv
// Front-end fetch stage: one icache read per instruction, predictor query for conditional
// branches, next-PC selection, instruction-queue push, ROB feedback relay and flush redirect.
module instruction_fetcher #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  Sys_clk,
    input  logic                  Sys_rst,
    input  logic                  Sys_rdy,
    instruction_fetcher_if.master bus
);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {REQ, WAIT_MEM, PRED, DISCARD} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic                  stall_reg, stall_next;
    logic [INST_WIDTH-1:0] inst_reg, inst_next;

    logic                  ific_en_reg, ific_en_next;
    logic [ADDR_WIDTH-1:0] ific_pc_reg, ific_pc_next;
    logic                  iq_en_reg, iq_en_next;
    logic [INST_WIDTH-1:0] iq_inst_reg, iq_inst_next;
    logic [ADDR_WIDTH-1:0] iq_pc_reg, iq_pc_next;
    logic                  iq_taken_reg, iq_taken_next;

    logic                  fb_en_reg;
    logic                  fb_result_reg;
    logic [ADDR_WIDTH-1:0] fb_pc_reg;

    // JAL target comes straight from the returning data; branch target from the latched word
    logic [ADDR_WIDTH-1:0] imm_j;
    logic [ADDR_WIDTH-1:0] imm_b;
    logic [ADDR_WIDTH-1:0] pc_plus4;

    assign imm_j = {{(ADDR_WIDTH-21){bus.ICIF_inst[31]}}, bus.ICIF_inst[31], bus.ICIF_inst[19:12],
                    bus.ICIF_inst[20], bus.ICIF_inst[30:21], 1'b0};
    assign imm_b = {{(ADDR_WIDTH-13){inst_reg[31]}}, inst_reg[31], inst_reg[7],
                    inst_reg[30:25], inst_reg[11:8], 1'b0};
    assign pc_plus4 = pc_reg + ADDR_WIDTH'(4);

    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            state_reg     <= REQ;
            pc_reg        <= RESET_PC;
            stall_reg     <= 1'b0;
            inst_reg      <= '0;
            ific_en_reg   <= 1'b0;
            ific_pc_reg   <= '0;
            iq_en_reg     <= 1'b0;
            iq_inst_reg   <= '0;
            iq_pc_reg     <= '0;
            iq_taken_reg  <= 1'b0;
            fb_en_reg     <= 1'b0;
            fb_result_reg <= 1'b0;
            fb_pc_reg     <= '0;
        end else if (Sys_rdy) begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            stall_reg     <= stall_next;
            inst_reg      <= inst_next;
            ific_en_reg   <= ific_en_next;
            ific_pc_reg   <= ific_pc_next;
            iq_en_reg     <= iq_en_next;
            iq_inst_reg   <= iq_inst_next;
            iq_pc_reg     <= iq_pc_next;
            iq_taken_reg  <= iq_taken_next;
            fb_en_reg     <= bus.ROBIF_branch_en;
            fb_result_reg <= bus.ROBIF_branch_result;
            fb_pc_reg     <= bus.ROBIF_branch_pc;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        stall_next    = stall_reg;
        inst_next     = inst_reg;
        ific_en_next  = 1'b0;
        ific_pc_next  = ific_pc_reg;
        iq_en_next    = 1'b0;
        iq_inst_next  = iq_inst_reg;
        iq_pc_next    = iq_pc_reg;
        iq_taken_next = iq_taken_reg;

        if (bus.ROBIF_flush_en) begin
            // An icache read still in flight must be swallowed before fetching again
            pc_next    = bus.ROBIF_flush_pc;
            stall_next = 1'b0;
            if ((state_reg == WAIT_MEM || state_reg == DISCARD) && !bus.ICIF_en)
                state_next = DISCARD;
            else
                state_next = REQ;
        end else begin
            case (state_reg)
                REQ: begin
                    if (!bus.IQIF_full && !stall_reg) begin
                        ific_en_next = 1'b1;
                        ific_pc_next = pc_reg;
                        state_next   = WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (bus.ICIF_en) begin
                        inst_next     = bus.ICIF_inst;
                        iq_inst_next  = bus.ICIF_inst;
                        iq_pc_next    = pc_reg;
                        iq_taken_next = 1'b0;
                        state_next    = REQ;
                        case (bus.ICIF_inst[6:0])
                            OP_BRANCH: state_next = PRED;
                            OP_JAL: begin
                                iq_en_next = 1'b1;
                                pc_next    = pc_reg + imm_j;
                            end
                            OP_JALR: begin
                                iq_en_next = 1'b1;
                                stall_next = 1'b1;
                            end
                            default: begin
                                iq_en_next = 1'b1;
                                pc_next    = pc_plus4;
                            end
                        endcase
                    end
                end
                PRED: begin
                    if (bus.PDIF_en) begin
                        iq_en_next    = 1'b1;
                        iq_inst_next  = inst_reg;
                        iq_pc_next    = pc_reg;
                        iq_taken_next = bus.PDIF_predict_result;
                        pc_next       = bus.PDIF_predict_result ? pc_reg + imm_b : pc_plus4;
                        state_next    = REQ;
                    end
                end
                DISCARD: begin
                    if (bus.ICIF_en)
                        state_next = REQ;
                end
                default: state_next = REQ;
            endcase
        end
    end

    // Pulses are masked while stalled globally; the held register replays them once on resume
    assign bus.IFIC_en            = ific_en_reg & Sys_rdy;
    assign bus.IFIC_pc            = ific_pc_reg;
    assign bus.IFPD_predict_en    = (state_reg == PRED) & Sys_rdy;
    assign bus.IFPD_pc            = pc_reg;
    assign bus.IFPD_feedback_en   = fb_en_reg & Sys_rdy;
    assign bus.IFPD_branch_result = fb_result_reg;
    assign bus.IFPD_feedback_pc   = fb_pc_reg;
    assign bus.IFIQ_en            = iq_en_reg & Sys_rdy;
    assign bus.IFIQ_inst          = iq_inst_reg;
    assign bus.IFIQ_pc            = iq_pc_reg;
    assign bus.IFIQ_pred_taken    = iq_taken_reg;
endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher: directed scenarios plus a randomized
// instruction stream compared against an arithmetic next-PC reference model.
module tb_instruction_fetcher;
    logic Sys_clk = 1'b0;
    logic Sys_rst;
    logic Sys_rdy;

    instruction_fetcher_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

    instruction_fetcher #(
        .ADDR_WIDTH(32),
        .INST_WIDTH(32),
        .RESET_PC  (32'h0)
    ) dut (
        .Sys_clk(Sys_clk),
        .Sys_rst(Sys_rst),
        .Sys_rdy(Sys_rdy),
        .bus    (bus)
    );

    always #5 Sys_clk = ~Sys_clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_pc;

    // Observations captured by the driver tasks
    bit          obs_got;
    logic [31:0] obs_req_pc;
    bit          obs_saw_pred;
    logic [31:0] obs_pred_pc;
    bit          obs_push_en;
    logic [31:0] obs_push_inst;
    logic [31:0] obs_push_pc;
    bit          obs_push_taken;

    function automatic bit is_branch(logic [31:0] inst);
        return inst[6:0] == 7'b1100011;
    endfunction

    // Next fetch address from the instruction's architectural meaning, as signed offsets
    function automatic logic [31:0] ref_next(logic [31:0] inst, logic [31:0] pc, bit taken);
        int off;
        off = 4;
        if (inst[6:0] == 7'b1100011 && taken)
            off = int'(inst[11:8]) * 2 + int'(inst[30:25]) * 32 + int'(inst[7]) * 2048
                  - int'(inst[31]) * 4096;
        else if (inst[6:0] == 7'b1101111)
            off = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096
                  - int'(inst[31]) * 1048576;
        return pc + 32'(off);
    endfunction

    task automatic tick();
        @(posedge Sys_clk);
        #1;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        obs_got = 1'b0;
        obs_req_pc = 'x;
        while (!bus.IFIC_en && n < 40) begin
            tick();
            n++;
        end
        if (bus.IFIC_en) begin
            obs_got = 1'b1;
            obs_req_pc = bus.IFIC_pc;
        end
    endtask

    // Called in the cycle IFIC_en is visible; icache answers k cycles later
    task automatic respond(input logic [31:0] inst, input int k, input bit pred, input int pdelay);
        repeat (k) tick();
        bus.ICIF_en = 1'b1;
        bus.ICIF_inst = inst;
        tick();
        bus.ICIF_en = 1'b0;
        obs_saw_pred = bus.IFPD_predict_en;
        obs_pred_pc = bus.IFPD_pc;
        if (is_branch(inst)) begin
            repeat (pdelay) tick();
            bus.PDIF_en = 1'b1;
            bus.PDIF_predict_result = pred;
            tick();
            bus.PDIF_en = 1'b0;
            bus.PDIF_predict_result = 1'b0;
        end
        obs_push_en = bus.IFIQ_en;
        obs_push_inst = bus.IFIQ_inst;
        obs_push_pc = bus.IFIQ_pc;
        obs_push_taken = bus.IFIQ_pred_taken;
    endtask

    // Redirect from the REQ state (cycle of a visible push)
    task automatic flush_to(input logic [31:0] target);
        bus.ROBIF_flush_en = 1'b1;
        bus.ROBIF_flush_pc = target;
        tick();
        bus.ROBIF_flush_en = 1'b0;
        exp_pc = target;
    endtask

    task automatic test_reset();
        Sys_rdy = 1'b1;
        Sys_rst = 1'b1;
        bus.ICIF_en = 1'b0; bus.ICIF_inst = '0;
        bus.PDIF_en = 1'b0; bus.PDIF_predict_result = 1'b0;
        bus.ROBIF_branch_en = 1'b1; bus.ROBIF_branch_result = 1'b1; bus.ROBIF_branch_pc = 32'h50;
        bus.ROBIF_flush_en = 1'b0; bus.ROBIF_flush_pc = '0;
        bus.IQIF_full = 1'b0;
        tick(); tick();
        n_checks++; if (bus.IFIC_en !== 1'b0) $display("FAIL reset_ific_en got %b want 0", bus.IFIC_en); else n_pass++;
        n_checks++; if (bus.IFIQ_en !== 1'b0) $display("FAIL reset_iq_en got %b want 0", bus.IFIQ_en); else n_pass++;
        n_checks++; if (bus.IFPD_feedback_en !== 1'b0) $display("FAIL reset_fb_en got %b want 0", bus.IFPD_feedback_en); else n_pass++;
        n_checks++; if (bus.IFPD_predict_en !== 1'b0) $display("FAIL reset_pred_en got %b want 0", bus.IFPD_predict_en); else n_pass++;
        n_checks++; if (bus.IFPD_pc !== 32'h0) $display("FAIL reset_pd_pc got %h want 0", bus.IFPD_pc); else n_pass++;
        bus.ROBIF_branch_en = 1'b0; bus.ROBIF_branch_result = 1'b0; bus.ROBIF_branch_pc = '0;
        Sys_rst = 1'b0;
        exp_pc = 32'h0;
        tick();
        n_checks++; if (bus.IFIC_en !== 1'b1 || bus.IFIC_pc !== 32'h0) $display("FAIL first_fetch got en=%b pc=%h want en=1 pc=00000000", bus.IFIC_en, bus.IFIC_pc); else n_pass++;
        $display("txn reset done");
    endtask

    task automatic test_basic();
        wait_req();
        n_checks++; if (!obs_got || obs_req_pc !== exp_pc) $display("FAIL basic_req got %b/%h want 1/%h", obs_got, obs_req_pc, exp_pc); else n_pass++;
        respond(32'h00000013, 2, 1'b0, 0);
        n_checks++; if ({obs_push_en, obs_push_pc, obs_push_inst, obs_push_taken} !== {1'b1, 32'h0, 32'h13, 1'b0})
            $display("FAIL basic_push got en=%b pc=%h inst=%h tk=%b want 1/0/13/0", obs_push_en, obs_push_pc, obs_push_inst, obs_push_taken); else n_pass++;
        n_checks++; if (obs_saw_pred !== 1'b0) $display("FAIL basic_no_pred got %b want 0", obs_saw_pred); else n_pass++;
        exp_pc = ref_next(32'h13, exp_pc, 1'b0);
        tick();
        n_checks++; if (bus.IFIC_en !== 1'b1 || bus.IFIC_pc !== exp_pc) $display("FAIL basic_latency got en=%b pc=%h want 1/%h", bus.IFIC_en, bus.IFIC_pc, exp_pc); else n_pass++;
        $display("txn addi pc=00000000 pushed, next %h", exp_pc);
        respond(32'h00000013, 1, 1'b0, 0);
        flush_to(32'h10);
    endtask

    task automatic test_branch();
        logic [31:0] beq;
        beq = 32'h00000463;
        for (int t = 1; t >= 0; t--) begin
            wait_req();
            n_checks++; if (!obs_got || obs_req_pc !== 32'h10) $display("FAIL br%0d_req got %b/%h want 1/00000010", t, obs_got, obs_req_pc); else n_pass++;
            respond(beq, 1, t[0], t);
            n_checks++; if (obs_saw_pred !== 1'b1 || obs_pred_pc !== 32'h10) $display("FAIL br%0d_pred_req got %b/%h want 1/00000010", t, obs_saw_pred, obs_pred_pc); else n_pass++;
            n_checks++; if ({obs_push_en, obs_push_pc, obs_push_taken} !== {1'b1, 32'h10, t[0]})
                $display("FAIL br%0d_push got en=%b pc=%h tk=%b want 1/00000010/%0d", t, obs_push_en, obs_push_pc, obs_push_taken, t); else n_pass++;
            exp_pc = ref_next(beq, 32'h10, t[0]);
            wait_req();
            n_checks++; if (!obs_got || obs_req_pc !== exp_pc) $display("FAIL br%0d_next got %h want %h", t, obs_req_pc, exp_pc); else n_pass++;
            $display("txn beq taken=%0d next %h", t, exp_pc);
            respond(32'h00000013, 0, 1'b0, 0);
            flush_to(t == 1 ? 32'h10 : 32'h20);
        end
    endtask

    task automatic test_jal();
        wait_req();
        respond(32'h0100006F, 0, 1'b0, 0);
        n_checks++; if (obs_saw_pred !== 1'b0) $display("FAIL jal_no_pred got %b want 0", obs_saw_pred); else n_pass++;
        n_checks++; if ({obs_push_en, obs_push_pc, obs_push_taken} !== {1'b1, 32'h20, 1'b0})
            $display("FAIL jal_push got en=%b pc=%h tk=%b want 1/00000020/0", obs_push_en, obs_push_pc, obs_push_taken); else n_pass++;
        exp_pc = ref_next(32'h0100006F, 32'h20, 1'b0);
        wait_req();
        n_checks++; if (!obs_got || obs_req_pc !== 32'h30 || exp_pc !== 32'h30) $display("FAIL jal_next got %h want 00000030", obs_req_pc); else n_pass++;
        $display("txn jal pc=00000020 next %h", obs_req_pc);
        respond(32'h00000013, 1, 1'b0, 0);
        flush_to(32'h40);
    endtask

    task automatic test_jalr_stall();
        int reqs;
        wait_req();
        respond(32'h00008067, 1, 1'b0, 0);
        n_checks++; if ({obs_push_en, obs_push_pc, obs_push_taken} !== {1'b1, 32'h40, 1'b0})
            $display("FAIL jalr_push got en=%b pc=%h tk=%b want 1/00000040/0", obs_push_en, obs_push_pc, obs_push_taken); else n_pass++;
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.IFIC_en) reqs++;
        end
        n_checks++; if (reqs != 0) $display("FAIL jalr_stall got %0d requests want 0", reqs); else n_pass++;
        flush_to(32'h100);
        wait_req();
        n_checks++; if (!obs_got || obs_req_pc !== 32'h100) $display("FAIL jalr_redirect got %b/%h want 1/00000100", obs_got, obs_req_pc); else n_pass++;
        $display("txn jalr stall released to %h", obs_req_pc);
        respond(32'h00000013, 1, 1'b0, 0);
        exp_pc = 32'h104;
    endtask

    task automatic test_flush_wait_mem();
        int bad;
        wait_req();
        bus.ROBIF_flush_en = 1'b1; bus.ROBIF_flush_pc = 32'h200;
        tick();
        bus.ROBIF_flush_en = 1'b0;
        bad = 0;
        if (bus.IFIQ_en || bus.IFIC_en) bad++;
        tick();
        if (bus.IFIQ_en || bus.IFIC_en) bad++;
        tick();
        if (bus.IFIQ_en || bus.IFIC_en) bad++;
        bus.ICIF_en = 1'b1; bus.ICIF_inst = 32'h00000013;
        tick();
        bus.ICIF_en = 1'b0;
        n_checks++; if (bus.IFIQ_en !== 1'b0) $display("FAIL discard_push got %b want 0", bus.IFIQ_en); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL discard_quiet got %0d pulses want 0", bad); else n_pass++;
        tick();
        n_checks++; if (bus.IFIC_en !== 1'b1 || bus.IFIC_pc !== 32'h200) $display("FAIL discard_redirect got %b/%h want 1/00000200", bus.IFIC_en, bus.IFIC_pc); else n_pass++;
        // flush coinciding with returning data: data dropped, no push
        bus.ICIF_en = 1'b1; bus.ICIF_inst = 32'h00000013;
        bus.ROBIF_flush_en = 1'b1; bus.ROBIF_flush_pc = 32'h280;
        tick();
        bus.ICIF_en = 1'b0; bus.ROBIF_flush_en = 1'b0;
        n_checks++; if (bus.IFIQ_en !== 1'b0) $display("FAIL flush_cancel got %b want 0", bus.IFIQ_en); else n_pass++;
        tick();
        n_checks++; if (bus.IFIC_en !== 1'b1 || bus.IFIC_pc !== 32'h280) $display("FAIL flush_hit_redirect got %b/%h want 1/00000280", bus.IFIC_en, bus.IFIC_pc); else n_pass++;
        $display("txn flush in WAIT_MEM handled, fetching %h", bus.IFIC_pc);
        respond(32'h00000013, 0, 1'b0, 0);
        n_checks++; if (obs_push_en !== 1'b1 || obs_push_pc !== 32'h280) $display("FAIL post_flush_push got %b/%h want 1/00000280", obs_push_en, obs_push_pc); else n_pass++;
        exp_pc = 32'h284;
    endtask

    task automatic test_iq_full();
        int reqs;
        bus.IQIF_full = 1'b1;
        reqs = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.IFIC_en) reqs++;
        end
        n_checks++; if (reqs != 0) $display("FAIL iq_full_hold got %0d requests want 0", reqs); else n_pass++;
        bus.IQIF_full = 1'b0;
        tick();
        n_checks++; if (bus.IFIC_en !== 1'b1 || bus.IFIC_pc !== exp_pc) $display("FAIL iq_full_release got %b/%h want 1/%h", bus.IFIC_en, bus.IFIC_pc, exp_pc); else n_pass++;
        $display("txn iq_full released, fetching %h", exp_pc);
        respond(32'h00000013, 1, 1'b0, 0);
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_feedback();
        logic        en, res;
        logic [31:0] fpc;
        int          errs;
        wait_req();
        respond(32'h00008067, 0, 1'b0, 0);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            en = 1'($urandom); res = 1'($urandom); fpc = $urandom;
            bus.ROBIF_branch_en = en; bus.ROBIF_branch_result = res; bus.ROBIF_branch_pc = fpc;
            tick();
            if (bus.IFPD_feedback_en !== en || bus.IFPD_branch_result !== res || bus.IFPD_feedback_pc !== fpc) begin
                errs++;
                $display("FAIL feedback_rand%0d got %b/%b/%h want %b/%b/%h", i, bus.IFPD_feedback_en, bus.IFPD_branch_result, bus.IFPD_feedback_pc, en, res, fpc);
            end
        end
        n_checks++; if (errs != 0) $display("FAIL feedback_stream got %0d errors want 0", errs); else n_pass++;
        bus.ROBIF_branch_en = 1'b1; bus.ROBIF_branch_result = 1'b1; bus.ROBIF_branch_pc = 32'h50;
        bus.ROBIF_flush_en = 1'b1; bus.ROBIF_flush_pc = 32'h400;
        tick();
        bus.ROBIF_branch_en = 1'b0; bus.ROBIF_branch_result = 1'b0; bus.ROBIF_flush_en = 1'b0;
        n_checks++; if ({bus.IFPD_feedback_en, bus.IFPD_branch_result, bus.IFPD_feedback_pc} !== {1'b1, 1'b1, 32'h50})
            $display("FAIL feedback_flush got %b/%b/%h want 1/1/00000050", bus.IFPD_feedback_en, bus.IFPD_branch_result, bus.IFPD_feedback_pc); else n_pass++;
        tick();
        n_checks++; if (bus.IFPD_feedback_en !== 1'b0) $display("FAIL feedback_pulse got %b want 0", bus.IFPD_feedback_en); else n_pass++;
        wait_req();
        n_checks++; if (!obs_got || obs_req_pc !== 32'h400) $display("FAIL feedback_redirect got %b/%h want 1/00000400", obs_got, obs_req_pc); else n_pass++;
        $display("txn feedback relayed, fetching %h", obs_req_pc);
        respond(32'h00000013, 1, 1'b0, 0);
        exp_pc = 32'h404;
    endtask

    task automatic test_sys_rdy();
        int          pulses;
        logic [31:0] beq;
        wait_req();
        tick();
        Sys_rdy = 1'b0;
        bus.ROBIF_branch_en = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            bus.ICIF_en = (i == 2); bus.ICIF_inst = 32'h0100006F;
            tick();
            if (bus.IFIC_en || bus.IFIQ_en || bus.IFPD_predict_en || bus.IFPD_feedback_en) pulses++;
        end
        bus.ICIF_en = 1'b0; bus.ROBIF_branch_en = 1'b0;
        n_checks++; if (pulses != 0) $display("FAIL rdy_low_pulses got %0d want 0", pulses); else n_pass++;
        Sys_rdy = 1'b1;
        n_checks++; if (bus.IFIC_en !== 1'b0 || bus.IFIQ_en !== 1'b0) $display("FAIL rdy_resume got ific=%b iq=%b want 0/0", bus.IFIC_en, bus.IFIQ_en); else n_pass++;
        beq = {1'b1, 6'h15, 13'h0, 5'h0, 4'h6, 1'b1, 7'b1100011};
        respond(beq, 0, 1'b1, 0);
        n_checks++; if ({obs_push_en, obs_push_pc, obs_push_taken} !== {1'b1, exp_pc, 1'b1})
            $display("FAIL rdy_hold_pc got en=%b pc=%h tk=%b want 1/%h/1", obs_push_en, obs_push_pc, obs_push_taken, exp_pc); else n_pass++;
        exp_pc = ref_next(beq, exp_pc, 1'b1);
        wait_req();
        n_checks++; if (!obs_got || obs_req_pc !== exp_pc) $display("FAIL rdy_next got %b/%h want 1/%h", obs_got, obs_req_pc, exp_pc); else n_pass++;
        $display("txn rdy hold done, fetching %h", exp_pc);
        respond(32'h00000013, 0, 1'b0, 0);
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_random();
        logic [6:0]  others [5];
        logic [31:0] r, inst;
        logic [6:0]  op;
        bit          pred;
        int          errs;
        others[0] = 7'b0010011; others[1] = 7'b0110011; others[2] = 7'b0000011;
        others[3] = 7'b0100011; others[4] = 7'b0110111;
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            case ($urandom_range(0, 2))
                0:       op = 7'b1100011;
                1:       op = 7'b1101111;
                default: op = others[$urandom_range(0, 4)];
            endcase
            inst = {r[31:7], op};
            pred = 1'($urandom);
            wait_req();
            if (!obs_got || obs_req_pc !== exp_pc) begin
                errs++;
                $display("FAIL rand%0d_req got %b/%h want 1/%h", i, obs_got, obs_req_pc, exp_pc);
            end
            respond(inst, $urandom_range(0, 3), pred, $urandom_range(0, 2));
            if ({obs_push_en, obs_push_inst, obs_push_pc, obs_push_taken} !== {1'b1, inst, exp_pc, is_branch(inst) & pred}
                || obs_saw_pred !== is_branch(inst)) begin
                errs++;
                $display("FAIL rand%0d_push got en=%b inst=%h pc=%h tk=%b pq=%b want 1/%h/%h/%b/%b", i, obs_push_en, obs_push_inst,
                         obs_push_pc, obs_push_taken, obs_saw_pred, inst, exp_pc, is_branch(inst) & pred, is_branch(inst));
            end
            $display("txn %0d pc=%h inst=%h pred=%0d", i, exp_pc, inst, is_branch(inst) & pred);
            exp_pc = ref_next(inst, exp_pc, pred);
        end
        wait_req();
        n_checks++; if (!obs_got || obs_req_pc !== exp_pc) $display("FAIL rand_final got %b/%h want 1/%h", obs_got, obs_req_pc, exp_pc); else n_pass++;
        n_checks++; if (errs != 0) $display("FAIL rand_stream got %0d errors want 0", errs); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_jal();
        test_jalr_stall();
        test_flush_wait_mem();
        test_iq_full();
        test_feedback();
        test_sys_rdy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
